// File: rtl/pdm_tx_modulator_pkg.sv
// Shared constants for the PCM-to-PDM transmitter: FSM encoding, default widths,
// full-scale feedback value and integrator saturation limits.
package pdm_tx_modulator_pkg;

   localparam int PDM_BUS_WIDTH  = 16;
   localparam int PDM_FIFO_DEPTH = 4;
   localparam int PDM_ACC_WIDTH  = 20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   // Feedback magnitude: the PDM bit stands for +/- one PCM full scale.
   function automatic longint full_scale(input int bus_width);
      return longint'(1) << (bus_width - 1);
   endfunction

   function automatic longint acc_max(input int acc_width);
      return (longint'(1) << (acc_width - 1)) - 1;
   endfunction

   function automatic longint acc_min(input int acc_width);
      return -(longint'(1) << (acc_width - 1));
   endfunction

endpackage

// File: rtl/pdm_tx_modulator_fifo.sv
// Small synchronous sample FIFO; push when not full, pop when not empty,
// clear_i empties it and wins over a same-cycle push or pop.
module pcm_sample_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int BUS_WIDTH  = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            clear_i,
   input  logic                            push_i,
   input  logic                            pop_i,
   input  logic [BUS_WIDTH-1:0]            data_i,
   output logic [BUS_WIDTH-1:0]            data_o,
   output logic [$clog2(FIFO_DEPTH):0]     level_o,
   output logic                            full_o,
   output logic                            empty_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic                 do_push, do_pop;

   assign full_o  = (level_q == LW'(FIFO_DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni && !clear_i && do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/pdm_tx_modulator.sv
// PCM-to-PDM transmitter: buffers PCM samples, pops one per ce_pcm and runs a
// saturating 2nd-order sigma-delta modulator producing one bit per mclk rise.
module pdm_tx_modulator
   import pdm_tx_modulator_pkg::*;
#(
   parameter int BUS_WIDTH  = PDM_BUS_WIDTH,
   parameter int FIFO_DEPTH = PDM_FIFO_DEPTH,
   parameter int ACC_WIDTH  = PDM_ACC_WIDTH
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_i,
   input  logic                           mclk,
   input  logic                           ce_pcm,
   input  logic                           enable_i,
   input  logic                           clear_i,
   input  logic                           pcm_valid_i,
   input  logic [BUS_WIDTH-1:0]           pcm_data_i,
   output logic                           pcm_ready_o,
   output logic                           pdm_data_o,
   output logic                           busy_o,
   output logic                           underrun_o,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

   localparam int SW = ACC_WIDTH + 2;
   localparam logic signed [SW-1:0]        FB_POS = SW'(full_scale(BUS_WIDTH));
   localparam logic signed [SW-1:0]        FB_NEG = -FB_POS;
   localparam logic signed [SW-1:0]        SAT_HI = SW'(acc_max(ACC_WIDTH));
   localparam logic signed [SW-1:0]        SAT_LO = SW'(acc_min(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ACC_HI = ACC_WIDTH'(acc_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ACC_LO = ACC_WIDTH'(acc_min(ACC_WIDTH));

   state_e                        state_q, state_d;
   logic                          mclk_q;
   logic                          tick;
   logic signed [ACC_WIDTH-1:0]   int1_q, int1_d, int2_q, int2_d;
   logic signed [BUS_WIDTH-1:0]   held_q, held_d;
   logic                          pdm_q, pdm_d;
   logic                          underrun_q, underrun_d;

   logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [BUS_WIDTH-1:0]          fifo_head;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic                          pop_state;

   logic signed [SW-1:0]          x_ext, fb, int1_ext, int2_ext, sum1, sum2, int1_new_ext;
   logic signed [ACC_WIDTH-1:0]   int1_new, int2_new;
   logic                          pdm_new;

   function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SAT_HI) return ACC_HI;
      if (v < SAT_LO) return ACC_LO;
      return ACC_WIDTH'(v);
   endfunction

   assign tick        = mclk & ~mclk_q;
   assign pcm_ready_o = ~fifo_full;
   assign fifo_push   = pcm_valid_i & pcm_ready_o;
   assign pop_state   = (state_q == ST_PRIME) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign fifo_pop    = ce_pcm & pop_state & ~fifo_empty;

   pcm_sample_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .BUS_WIDTH  (BUS_WIDTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_i),
      .clear_i (clear_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (pcm_data_i),
      .data_o  (fifo_head),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Modulator step; sums are kept two bits wider so saturation sees the true value.
   assign x_ext        = {{(SW-BUS_WIDTH){held_q[BUS_WIDTH-1]}}, held_q};
   assign fb           = pdm_q ? FB_POS : FB_NEG;
   assign int1_ext     = {{2{int1_q[ACC_WIDTH-1]}}, int1_q};
   assign int2_ext     = {{2{int2_q[ACC_WIDTH-1]}}, int2_q};
   assign sum1         = int1_ext + x_ext - fb;
   assign int1_new     = sat(sum1);
   assign int1_new_ext = {{2{int1_new[ACC_WIDTH-1]}}, int1_new};
   assign sum2         = int2_ext + int1_new_ext - fb;
   assign int2_new     = sat(sum2);
   assign pdm_new      = ~int2_new[ACC_WIDTH-1];

   always_comb begin
      state_d    = state_q;
      int1_d     = int1_q;
      int2_d     = int2_q;
      held_d     = held_q;
      pdm_d      = pdm_q;
      underrun_d = underrun_q;

      if (fifo_pop) held_d = fifo_head;

      case (state_q)
         ST_IDLE: begin
            int1_d = '0;
            int2_d = '0;
            if (tick) pdm_d = ~pdm_q;
            if (enable_i) state_d = ST_PRIME;
         end
         ST_PRIME: begin
            if (!enable_i)     state_d = ST_IDLE;
            else if (fifo_pop) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (tick) begin
               int1_d = int1_new;
               int2_d = int2_new;
               pdm_d  = pdm_new;
            end
            if (ce_pcm && fifo_empty) underrun_d = 1'b1;
            if (!enable_i) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (tick) begin
               int1_d = int1_new;
               int2_d = int2_new;
               pdm_d  = pdm_new;
            end
            // An empty strobe here marks the natural end of the stream, not an underrun.
            if (enable_i)                  state_d = ST_RUN;
            else if (ce_pcm && fifo_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q    <= ST_IDLE;
         mclk_q     <= 1'b0;
         int1_q     <= '0;
         int2_q     <= '0;
         held_q     <= '0;
         pdm_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else if (clear_i) begin
         state_q    <= enable_i ? ST_PRIME : ST_IDLE;
         mclk_q     <= 1'b0;
         int1_q     <= '0;
         int2_q     <= '0;
         held_q     <= '0;
         pdm_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mclk_q     <= mclk;
         int1_q     <= int1_d;
         int2_q     <= int2_d;
         held_q     <= held_d;
         pdm_q      <= pdm_d;
         underrun_q <= underrun_d;
      end
   end

   assign pdm_data_o   = pdm_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign underrun_o   = underrun_q;
   assign fifo_level_o = fifo_level;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// Directed self-checking bench for pdm_tx_modulator: reset, idle pattern, DC
// densities, backpressure/order, flush, underrun and mid-operation reset.
module tb_pdm_tx_modulator;

   localparam int BW = 16;
   localparam int FD = 4;
   localparam int AW = 20;
   localparam int LW = $clog2(FD) + 1;

   logic          wb_clk_i    = 1'b0;
   logic          wb_rst_i    = 1'b0;
   logic          mclk        = 1'b0;
   logic          ce_pcm      = 1'b0;
   logic          enable_i    = 1'b0;
   logic          clear_i     = 1'b0;
   logic          pcm_valid_i = 1'b0;
   logic [BW-1:0] pcm_data_i  = '0;
   logic          pcm_ready_o;
   logic          pdm_data_o;
   logic          busy_o;
   logic          underrun_o;
   logic [LW-1:0] fifo_level_o;

   int tests_run    = 0;
   int tests_failed = 0;

   pdm_tx_modulator #(
      .BUS_WIDTH  (BW),
      .FIFO_DEPTH (FD),
      .ACC_WIDTH  (AW)
   ) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .mclk         (mclk),
      .ce_pcm       (ce_pcm),
      .enable_i     (enable_i),
      .clear_i      (clear_i),
      .pcm_valid_i  (pcm_valid_i),
      .pcm_data_i   (pcm_data_i),
      .pcm_ready_o  (pcm_ready_o),
      .pdm_data_o   (pdm_data_o),
      .busy_o       (busy_o),
      .underrun_o   (underrun_o),
      .fifo_level_o (fifo_level_o)
   );

   // mclk runs at a quarter of wb_clk_i, its edges offset from the wb_clk_i rising edges.
   always #5  wb_clk_i = ~wb_clk_i;
   always #20 mclk     = ~mclk;

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b0;
      cycles(2);
      tests_run++; if (pdm_data_o !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset_pdm: got %b expected 0", pdm_data_o); end
      tests_run++; if (pcm_ready_o !== 1'b1)    begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", pcm_ready_o); end
      tests_run++; if (busy_o !== 1'b0)         begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
      tests_run++; if (underrun_o !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun_o); end
      tests_run++; if (fifo_level_o !== 3'd0)   begin tests_failed++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level_o); end
      wb_rst_i = 1'b1;
   endtask

   task automatic test_idle();
      logic prev;
      logic first_seen;
      int   changes;
      prev       = pdm_data_o;
      first_seen = 1'b0;
      changes    = 0;
      for (int i = 0; i < 48; i++) begin
         cycles(1);
         if (pdm_data_o !== prev) begin
            if (!first_seen) begin
               first_seen = 1'b1;
               tests_run++;
               if (pdm_data_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_first_bit: got %b expected 1", pdm_data_o); end
            end
            changes++;
            prev = pdm_data_o;
         end
      end
      tests_run++; if (changes < 11 || changes > 13) begin tests_failed++; $display("[TB] FAIL idle_toggle_count: got %0d expected 11..13", changes); end
      tests_run++; if (busy_o !== 1'b0)       begin tests_failed++; $display("[TB] FAIL idle_busy: got %b expected 0", busy_o); end
      tests_run++; if (pcm_ready_o !== 1'b1)  begin tests_failed++; $display("[TB] FAIL idle_ready: got %b expected 1", pcm_ready_o); end
   endtask

   task automatic test_dc(input logic [BW-1:0] val, input int lo, input int hi);
      int ones;
      enable_i = 1'b0;
      clear_i  = 1'b1;
      cycles(1);
      clear_i     = 1'b0;
      pcm_valid_i = 1'b1;
      pcm_data_i  = val;
      cycles(4);
      tests_run++; if (fifo_level_o !== 3'd4) begin tests_failed++; $display("[TB] FAIL dc_%h_prefill: got %0d expected 4", val, fifo_level_o); end
      enable_i = 1'b1;
      cycles(1);
      ce_pcm = 1'b1;
      cycles(1);
      ce_pcm = 1'b0;
      ones = 0;
      // One ce_pcm and exactly one mclk tick per 4-cycle group; valid stays high to refill.
      for (int g = 0; g < 16 + 1024; g++) begin
         ce_pcm = 1'b1;
         cycles(1);
         ce_pcm = 1'b0;
         cycles(3);
         if (g >= 16 && pdm_data_o === 1'b1) ones++;
      end
      tests_run++; if (ones < lo || ones > hi)  begin tests_failed++; $display("[TB] FAIL dc_%h_ones: got %0d expected %0d..%0d", val, ones, lo, hi); end
      tests_run++; if (dut.held_q !== val)      begin tests_failed++; $display("[TB] FAIL dc_%h_held: got %h expected %h", val, dut.held_q, val); end
      tests_run++; if (underrun_o !== 1'b0)     begin tests_failed++; $display("[TB] FAIL dc_%h_underrun: got %b expected 0", val, underrun_o); end
      tests_run++; if (busy_o !== 1'b1)         begin tests_failed++; $display("[TB] FAIL dc_%h_busy: got %b expected 1", val, busy_o); end
      pcm_valid_i = 1'b0;
      enable_i    = 1'b0;
      clear_i     = 1'b1;
      cycles(1);
      clear_i = 1'b0;
   endtask

   logic [BW-1:0] bp_vals [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

   task automatic test_backpressure();
      int exp_level;
      enable_i = 1'b0;
      clear_i  = 1'b1;
      cycles(1);
      clear_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pcm_valid_i = 1'b1;
         pcm_data_i  = bp_vals[i];
         cycles(1);
         exp_level = (i + 1 < 4) ? i + 1 : 4;
         tests_run++; if (fifo_level_o !== LW'(exp_level)) begin tests_failed++; $display("[TB] FAIL bp_level_%0d: got %0d expected %0d", i, fifo_level_o, exp_level); end
         tests_run++; if (pcm_ready_o !== (i + 1 < 4))      begin tests_failed++; $display("[TB] FAIL bp_ready_%0d: got %b expected %b", i, pcm_ready_o, (i + 1 < 4)); end
      end
      pcm_valid_i = 1'b0;
      enable_i    = 1'b1;
      cycles(1);
      tests_run++; if (busy_o !== 1'b1)       begin tests_failed++; $display("[TB] FAIL bp_prime_busy: got %b expected 1", busy_o); end
      tests_run++; if (fifo_level_o !== 3'd4) begin tests_failed++; $display("[TB] FAIL bp_prime_level: got %0d expected 4", fifo_level_o); end
      ce_pcm = 1'b1;
      cycles(1);
      ce_pcm = 1'b0;
      tests_run++; if (fifo_level_o !== 3'd3)     begin tests_failed++; $display("[TB] FAIL bp_pop_level: got %0d expected 3", fifo_level_o); end
      tests_run++; if (dut.held_q !== bp_vals[0]) begin tests_failed++; $display("[TB] FAIL bp_pop_held: got %h expected %h", dut.held_q, bp_vals[0]); end
      tests_run++; if (pcm_ready_o !== 1'b1)      begin tests_failed++; $display("[TB] FAIL bp_pop_ready: got %b expected 1", pcm_ready_o); end
   endtask

   task automatic test_flush();
      enable_i = 1'b0;
      cycles(1);
      tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_enter_busy: got %b expected 1", busy_o); end
      for (int k = 0; k < 3; k++) begin
         ce_pcm = 1'b1;
         cycles(1);
         ce_pcm = 1'b0;
         tests_run++; if (dut.held_q !== bp_vals[k+1])   begin tests_failed++; $display("[TB] FAIL flush_held_%0d: got %h expected %h", k, dut.held_q, bp_vals[k+1]); end
         tests_run++; if (fifo_level_o !== LW'(2 - k))   begin tests_failed++; $display("[TB] FAIL flush_level_%0d: got %0d expected %0d", k, fifo_level_o, 2 - k); end
         tests_run++; if (busy_o !== 1'b1)               begin tests_failed++; $display("[TB] FAIL flush_busy_%0d: got %b expected 1", k, busy_o); end
         cycles(2);
      end
      ce_pcm = 1'b1;
      cycles(1);
      ce_pcm = 1'b0;
      tests_run++; if (busy_o !== 1'b0)           begin tests_failed++; $display("[TB] FAIL flush_idle_busy: got %b expected 0", busy_o); end
      tests_run++; if (underrun_o !== 1'b0)       begin tests_failed++; $display("[TB] FAIL flush_underrun: got %b expected 0", underrun_o); end
      tests_run++; if (dut.held_q !== bp_vals[3]) begin tests_failed++; $display("[TB] FAIL flush_final_held: got %h expected %h", dut.held_q, bp_vals[3]); end
   endtask

   task automatic test_underrun();
      enable_i = 1'b1;
      clear_i  = 1'b1;
      cycles(1);
      clear_i = 1'b0;
      tests_run++; if (busy_o !== 1'b1)       begin tests_failed++; $display("[TB] FAIL ur_clear_prime: got %b expected 1", busy_o); end
      pcm_valid_i = 1'b1;
      pcm_data_i  = 16'h1234;
      cycles(1);
      pcm_valid_i = 1'b0;
      ce_pcm      = 1'b1;
      cycles(1);
      ce_pcm = 1'b0;
      tests_run++; if (dut.held_q !== 16'h1234) begin tests_failed++; $display("[TB] FAIL ur_first_held: got %h expected 1234", dut.held_q); end
      tests_run++; if (underrun_o !== 1'b0)     begin tests_failed++; $display("[TB] FAIL ur_before: got %b expected 0", underrun_o); end
      cycles(2);
      ce_pcm = 1'b1;
      cycles(1);
      ce_pcm = 1'b0;
      tests_run++; if (underrun_o !== 1'b1)     begin tests_failed++; $display("[TB] FAIL ur_set: got %b expected 1", underrun_o); end
      tests_run++; if (dut.held_q !== 16'h1234) begin tests_failed++; $display("[TB] FAIL ur_held_kept: got %h expected 1234", dut.held_q); end
      cycles(2);
      ce_pcm      = 1'b1;
      pcm_valid_i = 1'b1;
      pcm_data_i  = 16'h5678;
      cycles(1);
      ce_pcm      = 1'b0;
      pcm_valid_i = 1'b0;
      tests_run++; if (fifo_level_o !== 3'd1)   begin tests_failed++; $display("[TB] FAIL ur_push_level: got %0d expected 1", fifo_level_o); end
      tests_run++; if (underrun_o !== 1'b1)     begin tests_failed++; $display("[TB] FAIL ur_push_sticky: got %b expected 1", underrun_o); end
      tests_run++; if (dut.held_q !== 16'h1234) begin tests_failed++; $display("[TB] FAIL ur_push_held: got %h expected 1234", dut.held_q); end
      cycles(3);
      tests_run++; if (underrun_o !== 1'b1)     begin tests_failed++; $display("[TB] FAIL ur_still_sticky: got %b expected 1", underrun_o); end
      clear_i = 1'b1;
      cycles(1);
      clear_i = 1'b0;
      tests_run++; if (underrun_o !== 1'b0)     begin tests_failed++; $display("[TB] FAIL ur_clear: got %b expected 0", underrun_o); end
      tests_run++; if (fifo_level_o !== 3'd0)   begin tests_failed++; $display("[TB] FAIL ur_clear_level: got %0d expected 0", fifo_level_o); end
      tests_run++; if (busy_o !== 1'b1)         begin tests_failed++; $display("[TB] FAIL ur_clear_busy: got %b expected 1", busy_o); end
   endtask

   task automatic test_reset_midop();
      enable_i    = 1'b1;
      pcm_valid_i = 1'b1;
      pcm_data_i  = 16'h7000;
      cycles(3);
      pcm_valid_i = 1'b0;
      ce_pcm      = 1'b1;
      cycles(1);
      ce_pcm = 1'b0;
      cycles(20);
      tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL midop_run_busy: got %b expected 1", busy_o); end
      wb_rst_i = 1'b0;
      cycles(1);
      tests_run++; if (pdm_data_o !== 1'b0)   begin tests_failed++; $display("[TB] FAIL midop_pdm: got %b expected 0", pdm_data_o); end
      tests_run++; if (pcm_ready_o !== 1'b1)  begin tests_failed++; $display("[TB] FAIL midop_ready: got %b expected 1", pcm_ready_o); end
      tests_run++; if (busy_o !== 1'b0)       begin tests_failed++; $display("[TB] FAIL midop_busy: got %b expected 0", busy_o); end
      tests_run++; if (underrun_o !== 1'b0)   begin tests_failed++; $display("[TB] FAIL midop_underrun: got %b expected 0", underrun_o); end
      tests_run++; if (fifo_level_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL midop_level: got %0d expected 0", fifo_level_o); end
      tests_run++; if (dut.held_q !== 16'h0)  begin tests_failed++; $display("[TB] FAIL midop_held: got %h expected 0000", dut.held_q); end
      wb_rst_i = 1'b1;
      enable_i = 1'b0;
      cycles(1);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_dc(16'h0000, 510, 514);
      test_dc(16'h4000, 765, 771);
      test_dc(16'hC000, 253, 259);
      test_backpressure();
      test_flush();
      test_underrun();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
